// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants for the ALU sequencer and ALU
package alu_pkg;

  localparam int W     = 16;
  localparam int NREGS = 8;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_SHL1  = 3'b010;
  localparam logic [2:0] OP_ROTR1 = 3'b011;
  localparam logic [2:0] OP_AND   = 3'b100;
  localparam logic [2:0] OP_OR    = 3'b101;
  localparam logic [2:0] OP_XOR   = 3'b110;
  localparam logic [2:0] OP_NOT   = 3'b111;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_WB    = 2'd3;

endpackage

// File: rtl/alu_sequencer_alu.sv
// rtl/alu_sequencer_alu.sv - combinational 16-bit ALU with carry/borrow out
module ALU #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   op,
  output logic [W-1:0] y,
  output logic         c_out
);
  import alu_pkg::*;

  logic [W:0] wide;

  // Result and carry; carry is only meaningful for add/sub (borrow for sub)
  always_comb begin
    wide  = '0;
    y     = '0;
    c_out = 1'b0;
    case (op)
      OP_ADD: begin
        wide  = {1'b0, a} + {1'b0, b};
        y     = wide[W-1:0];
        c_out = wide[W];
      end
      OP_SUB: begin
        wide  = {1'b0, a} - {1'b0, b};
        y     = wide[W-1:0];
        c_out = wide[W];
      end
      OP_SHL1:  y = {a[W-2:0], 1'b0};
      OP_ROTR1: y = {a[0], a[W-1:1]};
      OP_AND:   y = a & b;
      OP_OR:    y = a | b;
      OP_XOR:   y = a ^ b;
      default:  y = ~a;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - multi-cycle command sequencer owning an 8x16 register file
module alu_sequencer #(
  parameter int NREGS = 8,
  parameter int W     = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_ld,
  input  logic [2:0]               cmd_op,
  input  logic [$clog2(NREGS)-1:0] cmd_rd,
  input  logic [$clog2(NREGS)-1:0] cmd_ra,
  input  logic [$clog2(NREGS)-1:0] cmd_rb,
  input  logic [W-1:0]             cmd_imm,
  output logic                     done,
  output logic                     flag_z,
  output logic                     flag_c,
  input  logic [$clog2(NREGS)-1:0] dbg_addr,
  output logic [W-1:0]             dbg_data
);
  import alu_pkg::*;

  localparam int AW = $clog2(NREGS);

  logic [1:0]    state_q, state_d;
  logic          ld_q, ld_d;
  logic [2:0]    op_q, op_d;
  logic [AW-1:0] rd_q, rd_d, ra_q, ra_d, rb_q, rb_d;
  logic [W-1:0]  opa_q, opa_d, opb_q, opb_d, res_q, res_d;
  logic          carry_q, carry_d;
  logic          z_q, z_d, c_q, c_d;
  logic          done_q, done_d;
  logic [W-1:0]  regs_q [NREGS];
  logic [W-1:0]  regs_d [NREGS];

  logic [W-1:0]  alu_y;
  logic          alu_c;

  ALU #(.W(W)) u_alu (
    .a     (opa_q),
    .b     (opb_q),
    .op    (op_q),
    .y     (alu_y),
    .c_out (alu_c)
  );

  assign cmd_ready = (state_q == S_IDLE);
  assign done      = done_q;
  assign flag_z    = z_q;
  assign flag_c    = c_q;
  assign dbg_data  = regs_q[dbg_addr];

  // Next-state: accept in IDLE, fetch operands, capture ALU, write back
  always_comb begin
    state_d = state_q;
    ld_d    = ld_q;
    op_d    = op_q;
    rd_d    = rd_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    carry_d = carry_q;
    z_d     = z_q;
    c_d     = c_q;
    done_d  = 1'b0;
    regs_d  = regs_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          ld_d = cmd_ld;
          op_d = cmd_op;
          rd_d = cmd_rd;
          ra_d = cmd_ra;
          rb_d = cmd_rb;
          if (cmd_ld) begin
            res_d   = cmd_imm;
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        opa_d   = regs_q[ra_q];
        opb_d   = regs_q[rb_q];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        res_d = alu_y;
        // The ALU carry is only defined for add/sub, so it is ignored otherwise
        if (op_q == OP_ADD || op_q == OP_SUB) carry_d = alu_c;
        state_d = S_WB;
      end
      default: begin
        regs_d[rd_q] = res_q;
        z_d          = (res_q == '0);
        if (!ld_q && (op_q == OP_ADD || op_q == OP_SUB)) c_d = carry_q;
        done_d       = 1'b1;
        state_d      = S_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any in-flight command
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ld_q    <= 1'b0;
      op_q    <= '0;
      rd_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ld_q    <= ld_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      z_q     <= z_d;
      c_q     <= c_d;
      done_q  <= done_d;
      regs_q  <= regs_d;
    end
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle controller that sequences the 16-bit ALU datapath. It accepts one register-to-register command at a time over a valid/ready handshake and owns an 8 x 16 register file. For each command it fetches the operands, drives the ALU opcode, writes the result back, and records Z/C flags. It sits between the project's instruction/control source and the ALU, and is the only master of the ALU inputs.

## Interface
Parameters:
- `NREGS`, 8: register-file depth; register address width is log2(NREGS) = 3.
- `W`, 16: datapath width; must match the ALU.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset_n`  in  1  reset, asynchronous assert, active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept; high only in IDLE.
- `cmd_ld`  in  1  1 = load-immediate; 0 = ALU operation.
- `cmd_op`  in  3  ALU opcode: 000 add, 001 sub, 010 shl1, 011 rotr1, 100 and, 101 or, 110 xor, 111 not A.
- `cmd_rd`, `cmd_ra`, `cmd_rb`  in  3 each  destination, operand-A and operand-B register addresses.
- `cmd_imm`  in  W  immediate value for load-immediate.
- `done`  out  1  one-cycle pulse: writeback committed.
- `flag_z`, `flag_c`  out  1 each  registered flags.
- `dbg_addr`  in  3  observation read address.
- `dbg_data`  out  W  combinational read of `R[dbg_addr]`.

## Operation
- States: IDLE, FETCH, EXEC, WB.
- IDLE, `cmd_valid` = 1: latch the command fields.
  - `cmd_ld` = 0: go to FETCH.
  - `cmd_ld` = 1: load `cmd_imm` into the result register, go to WB.
- FETCH: latch operands `opA = R[ra]`, `opB = R[rb]`; go to EXEC.
- EXEC: the ALU sees `opA`, `opB`, `op`. Latch the ALU result and carry; go to WB.
- WB: write `R[rd]` from the result register and update flags. Assert `done` in the following cycle; go to IDLE.
- Flags:
  - Z is updated on every writeback, including load-immediate, and is 1 iff the written value == 0.
  - C is updated only for op 000/001: bit 16 of the 17-bit add, or the borrow-out of A - B (1 when A < B unsigned). It holds its value for all other ops and for load-immediate.
- Arithmetic is modulo 2^16.
  - shl1: bit 0 is filled with 0.
  - rotr1: `{A[0], A[15:1]}`.
  - op 111 ignores B.
- `cmd_rd` may equal `cmd_ra` or `cmd_rb`: operands are captured in FETCH, so the old value is used.
- `cmd_valid` while not in IDLE is ignored; the command is not queued. The source must hold it until `cmd_ready`.

## Timing
- Handshake: transfer occurs on the rising edge where `cmd_valid` and `cmd_ready` are both 1.
- `cmd_ready` = (state == IDLE). It is derived combinationally from the state register.
- ALU command, transfer on edge t0:
  - t1: operands latched.
  - t2: result latched.
  - t3: register and flags written; `done` = 1 for exactly the cycle following t3.
  - `cmd_ready` is 1 again in the same cycle as `done`, so the earliest next transfer is edge t4.
  - Throughput: 1 command per 4 cycles.
- Load-immediate, transfer on t0: write at t1, `done` in the cycle after t1. Throughput: 1 per 2 cycles.
- Dependent back-to-back commands read the new value, because writeback completes before the next FETCH.
- Reset (`reset_n` = 0, any time, including mid-command):
  - state = IDLE, all R = 0, operand and result registers = 0.
  - `done` = 0, `flag_z` = 0, `flag_c` = 0, `cmd_ready` = 1.
  - An in-flight command is aborted with no writeback.
- `dbg_data` reflects a write in the cycle after the writeback edge.

## Structure
- Shared package `alu_pkg`:
  - opcode localparams `OP_ADD` … `OP_NOT` (000 to 111);
  - state encoding `S_IDLE`=2'd0, `S_FETCH`=2'd1, `S_EXEC`=2'd2, `S_WB`=2'd3;
  - `W`, `NREGS`.
- One sub-module: the existing `ALU`, instantiated unchanged as `u_alu`.
- The sequencer captures the ALU's `C` only in EXEC of op 000/001, so the ALU's held carry on other ops is never observed.
- The register file is an internal array.

## Test plan
- Reset, then `dbg_addr` 0..7 → all `dbg_data` = 0x0000; `cmd_ready` = 1, `done` = 0, flags = 0.
- Load R1 = 0xFFFF, R2 = 0x0001; add R3 = R1 + R2:
  - R3 = 0x0000, Z = 1, C = 1;
  - `done` exactly 3 edges after transfer, then R3 visible on `dbg_data`.
- sub R4 = R2 - R1 (0x0001 - 0xFFFF) → R4 = 0x0002, C = 1 (borrow), Z = 0. Then xor R5 = R1 ^ R1 → R5 = 0, Z = 1, C still 1.
- Load R6 = 0x8001; shl1 R6 = R6 → 0x0002; then rotr1 R7 = R6 → 0x0001; then not R0 = R7 → 0xFFFE. C unchanged throughout.
- Hold `cmd_valid` continuously with a changing `cmd_rd`:
  - only commands sampled while `cmd_ready` = 1 execute;
  - ready low for exactly 3 cycles per ALU command;
  - dependent command R2 = R2 + R2 sees the prior writeback.
- Pull `reset_n` low during EXEC of an add to R3 → no write to R3, state IDLE immediately, `done` never pulses, `cmd_ready` = 1 while reset is held.
